// File: rtl/mult_control.sv
// Sequencing FSM for a shift-add multiplier: IDLE -> LOAD -> CALC x ITERATIONS -> DONE.
// Optional macro MULT_CTRL_EARLY_DONE_EN ends CALC as soon as the B register reads zero.
module mult_control #(
    parameter int ITERATIONS = 32,
    parameter int CNT_W      = 6
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iStart,
    input  logic             iB_LSB,
    input  logic             iB_Zero,
    output logic             a_sel,
    output logic             b_sel,
    output logic             prod_sel,
    output logic             add_sel,
    output logic             Shift_Enable,
    output logic             oBusy,
    output logic             oDone,
    output logic [CNT_W-1:0] oCount
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(ITERATIONS - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] next_count;
    logic             next_shift;
    logic             early_exit;
    logic             calc_exit;

`ifdef MULT_CTRL_EARLY_DONE_EN
    assign early_exit = iB_Zero;
`else
    logic unused_b_zero;
    assign unused_b_zero = iB_Zero;
    assign early_exit    = 1'b0;
`endif

    // The counter is never incremented on the exit cycle, so it saturates at its final value.
    assign calc_exit = (oCount == LAST_COUNT) || early_exit;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= IDLE;
            oCount       <= '0;
            Shift_Enable <= 1'b0;
        end else begin
            state        <= next_state;
            oCount       <= next_count;
            Shift_Enable <= next_shift;
        end
    end

    always_comb begin
        next_state = state;
        next_count = oCount;
        next_shift = Shift_Enable;
        a_sel      = 1'b0;
        b_sel      = 1'b0;
        prod_sel   = 1'b0;
        add_sel    = 1'b1;
        oBusy      = 1'b0;
        oDone      = 1'b0;
        case (state)
            IDLE: begin
                if (iStart) begin
                    next_state = LOAD;
                    next_count = '0;
                end
            end
            LOAD: begin
                a_sel      = 1'b1;
                b_sel      = 1'b1;
                prod_sel   = 1'b1;
                oBusy      = 1'b1;
                next_count = '0;
                next_state = CALC;
            end
            CALC: begin
                oBusy      = 1'b1;
                add_sel    = ~iB_LSB;
                next_shift = ~Shift_Enable;
                if (calc_exit) begin
                    next_state = DONE;
                end else begin
                    next_count = oCount + 1'b1;
                end
            end
            DONE: begin
                oDone      = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mult_control.sv
// Self-checking bench for mult_control: directed scenarios plus random traffic against a
// cycle-position reference model and a behavioural shift-add datapath checking the product.
module tb_mult_control;

    localparam int ITERATIONS = 32;
    localparam int CNT_W      = 6;
`ifdef MULT_CTRL_EARLY_DONE_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic             Clock;
    logic             Reset;
    logic             iStart;
    logic             iB_LSB;
    logic             iB_Zero;
    logic             a_sel;
    logic             b_sel;
    logic             prod_sel;
    logic             add_sel;
    logic             Shift_Enable;
    logic             oBusy;
    logic             oDone;
    logic [CNT_W-1:0] oCount;

    mult_control #(.ITERATIONS(ITERATIONS), .CNT_W(CNT_W)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .iStart(iStart),
        .iB_LSB(iB_LSB),
        .iB_Zero(iB_Zero),
        .a_sel(a_sel),
        .b_sel(b_sel),
        .prod_sel(prod_sel),
        .add_sel(add_sel),
        .Shift_Enable(Shift_Enable),
        .oBusy(oBusy),
        .oDone(oDone),
        .oCount(oCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    // Reference model: position in the operation (-1 idle, -2 done, 0 load, k>0 calc with count k-1).
    int          mPos       = -1;
    int          mCount     = 0;
    int          mCalcTotal = 0;
    logic [63:0] expProd    = '0;

    logic [31:0] opA   = '0;
    logic [31:0] opB   = '0;
    logic [63:0] dpA   = '0;
    logic [31:0] dpB   = '0;
    logic [63:0] dpP   = '0;
    bit          useDp = 1'b0;

    int   cyc            = 0;
    int   lastStartCycle = 0;
    int   lastDoneCycle  = -1;
    int   busyCount      = 0;
    int   toggleCount    = 0;
    logic prevShift      = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance model and datapath.
    task automatic applyStimulus(input logic rst, input logic start, input logic lsb, input logic zero);
        logic expA, expB, expP, expAdd, expBusy, expDone;
        int   expCount;
        @(negedge Clock);
        Reset  = rst;
        iStart = start;
        if (useDp) begin
            iB_LSB  = dpB[0];
            iB_Zero = (dpB == 32'd0);
        end else begin
            iB_LSB  = lsb;
            iB_Zero = zero;
        end
        #1;
        expA = 1'b0; expB = 1'b0; expP = 1'b0; expAdd = 1'b1;
        expBusy = 1'b0; expDone = 1'b0; expCount = mCount;
        if (mPos == 0) begin
            expA = 1'b1; expB = 1'b1; expP = 1'b1; expBusy = 1'b1; expCount = 0;
        end else if (mPos > 0) begin
            expBusy = 1'b1; expAdd = ~iB_LSB; expCount = mPos - 1;
        end else if (mPos == -2) begin
            expDone = 1'b1;
        end
        checkOutput("a_sel", 64'(a_sel), 64'(expA));
        checkOutput("b_sel", 64'(b_sel), 64'(expB));
        checkOutput("prod_sel", 64'(prod_sel), 64'(expP));
        checkOutput("add_sel", 64'(add_sel), 64'(expAdd));
        checkOutput("oBusy", 64'(oBusy), 64'(expBusy));
        checkOutput("oDone", 64'(oDone), 64'(expDone));
        checkOutput("oCount", 64'(oCount), 64'(expCount));
        checkOutput("Shift_Enable", 64'(Shift_Enable), 64'(mCalcTotal % 2));
        if (mPos == -2 && useDp) checkOutput("product", dpP, expProd);

        if (oDone === 1'b1) lastDoneCycle = cyc;
        if (oBusy === 1'b1) busyCount++;
        if (Shift_Enable !== prevShift) toggleCount++;
        prevShift = Shift_Enable;

        // Datapath follows the DUT's select lines, as the real one would.
        dpP = prod_sel ? 64'd0 : (add_sel ? dpP : dpP + dpA);
        dpA = a_sel ? {32'd0, opA} : (dpA << 1);
        dpB = b_sel ? opB : (dpB >> 1);

        if (rst) begin
            mPos = -1; mCount = 0; mCalcTotal = 0;
        end else if (mPos == -1) begin
            if (start) begin
                mPos = 0; mCount = 0; lastStartCycle = cyc;
            end
        end else if (mPos == 0) begin
            mPos = 1;
            expProd = {32'd0, opA} * {32'd0, opB};
        end else if (mPos > 0) begin
            mCalcTotal++;
            mCount = mPos - 1;
            if (mPos == ITERATIONS || (EARLY && iB_Zero)) mPos = -2;
            else mPos++;
        end else begin
            mPos = -1;
        end
        cyc++;
    endtask

    task automatic startWindow();
        busyCount     = 0;
        toggleCount   = 0;
        lastDoneCycle = -1;
        prevShift     = Shift_Enable;
    endtask

    initial begin
        Reset = 1'b1; iStart = 1'b0; iB_LSB = 1'b0; iB_Zero = 1'b0;
        repeat (2) @(posedge Clock);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // A=3, B=5 through the datapath; latency/busy/toggle counts for a whole operation
        useDp = 1'b1; opA = 32'd3; opB = 32'd5;
        startWindow();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        begin
            int calcN;
            calcN = EARLY ? 4 : ITERATIONS;
            checkOutput("latency_3x5", 64'(lastDoneCycle - lastStartCycle), 64'(calcN + 2));
            checkOutput("busy_cycles", 64'(busyCount), 64'(calcN + 1));
            checkOutput("shift_toggles", 64'(toggleCount), 64'(calcN));
        end
        checkOutput("product_15", dpP, 64'd15);
        useDp = 1'b0;

        // iB_LSB pattern 1,0,1,1 then a stray iStart at count 7
        startWindow();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < ITERATIONS + 10; i++) begin
            logic [3:0] pat;
            pat = 4'b1101;
            applyStimulus(1'b0, (i == 7), (i < 4) ? pat[i] : 1'b0, 1'b0);
        end
        checkOutput("latency_ignore_start", 64'(lastDoneCycle - lastStartCycle), 64'(ITERATIONS + 2));

        // Reset in the middle of CALC at count 10
        startWindow();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("no_done_after_abort", 64'(lastDoneCycle), 64'(-1));

        // iB_Zero raised at count 3
        startWindow();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < ITERATIONS + 8; i++) applyStimulus(1'b0, 1'b0, 1'b0, (i == 3));
        checkOutput("latency_bzero", 64'(lastDoneCycle - lastStartCycle), 64'(EARLY ? 6 : ITERATIONS + 2));

        // Random operands through the datapath, with stray starts and occasional resets
        useDp = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if (mPos == -1) begin
                opA = $urandom;
                opB = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            end
            applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 5) == 0), 1'b0, 1'b0);
        end

        // Random control inputs without the datapath
        useDp = 1'b0;
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_control.md
MULT_CONTROL -- requirements
Module: mult_control

Interface
REQ-001 Parameter ITERATIONS, default 32: number of shift-add iterations per multiply, equal to the operand width.
REQ-002 Parameter CNT_W, default 6: counter width; SHALL satisfy 2^CNT_W > ITERATIONS.
REQ-003 Clock  input  1  clock; all state updates on the rising edge.
REQ-004 Reset  input  1  reset, synchronous, active-high.
REQ-005 iStart  input  1  request a new multiply; sampled only in IDLE.
REQ-006 iB_LSB  input  1  LSB of the multiplier (B) register in the datapath.
REQ-007 iB_Zero  input  1  high when the B register is all zeros; used only under MULT_CTRL_EARLY_DONE_EN.
REQ-008 a_sel  output  1  1 = load operand A into the A register, 0 = load shifted A.
REQ-009 b_sel  output  1  1 = load operand B into the B register, 0 = load shifted B.
REQ-010 prod_sel  output  1  1 = clear the product register, 0 = load the add/hold result.
REQ-011 add_sel  output  1  0 = product takes product+A, 1 = product holds.
REQ-012 Shift_Enable  output  1  shift strobe; toggles once per iteration.
REQ-013 oBusy  output  1  high in LOAD and CALC.
REQ-014 oDone  output  1  one-cycle pulse in DONE; the product is valid from this cycle.
REQ-015 oCount  output  CNT_W  current iteration index.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, CALC and DONE, held in a state register.
REQ-017 IDLE: iStart=1 -> LOAD next cycle; otherwise stay in IDLE.
REQ-018 LOAD: lasts exactly one cycle with a_sel=1, b_sel=1, prod_sel=1, add_sel=1, oCount cleared to 0; then -> CALC.
REQ-019 CALC: a_sel=0, b_sel=0, prod_sel=0, add_sel = ~iB_LSB (combinational); oCount increments every cycle.
REQ-020 CALC SHALL exit to DONE on the cycle where oCount=ITERATIONS-1, giving exactly ITERATIONS CALC cycles.
REQ-021 Shift_Enable SHALL be a registered toggle, inverted on every CALC cycle and held constant in all other states.
REQ-022 DONE: lasts one cycle with oDone=1, prod_sel=0, add_sel=1; then -> IDLE.
REQ-023 IDLE outputs: prod_sel=0, add_sel=1, a_sel=0, b_sel=0, so the product is held indefinitely.
REQ-024 Latency: iStart sampled at edge N -> LOAD in cycle N+1, CALC in N+2..N+1+ITERATIONS, DONE in N+2+ITERATIONS.
REQ-025 iStart asserted outside IDLE SHALL be ignored, with no queuing; iStart held high across DONE SHALL start a new multiply from IDLE.
REQ-026 oCount SHALL saturate and never wrap within an operation; it holds its final value in DONE and IDLE until the next LOAD.

Reset
REQ-027 On Reset=1 at a clock edge, the next state SHALL be IDLE and Shift_Enable=0, oBusy=0, oDone=0, oCount=0, a_sel=0, b_sel=0, prod_sel=0, add_sel=1.
REQ-028 Reset SHALL override iStart and abort any state, including mid-CALC, with no oDone pulse.

Configuration
REQ-029 Macro MULT_CTRL_EARLY_DONE_EN defined: in CALC, iB_Zero=1 -> DONE next cycle regardless of oCount; oCount freezes at its value in that exit cycle.
REQ-030 MULT_CTRL_EARLY_DONE_EN undefined: iB_Zero is ignored, and every multiply takes exactly ITERATIONS CALC cycles.

Verification
REQ-031 Reset held 2 cycles, then released -> all outputs at REQ-027 values; IDLE persists with iStart=0.
REQ-032 iStart 1-cycle pulse, ITERATIONS=32 -> LOAD outputs (1,1,1) for 1 cycle, oBusy high 33 cycles, oDone pulse 34 cycles after the sampling edge, Shift_Enable toggled 32 times.
REQ-033 iB_LSB driven 1,0,1,1 in the first four CALC cycles -> add_sel 0,1,0,0; with the datapath, A=3 and B=5 give product 15 at oDone.
REQ-034 iStart pulsed at CALC oCount=7 -> ignored; oDone still at the nominal cycle.
REQ-035 Reset asserted at CALC oCount=10 -> IDLE next edge, oDone never pulses, oCount=0.
REQ-036 With MULT_CTRL_EARLY_DONE_EN, iB_Zero=1 at oCount=3 -> DONE next cycle with oCount=3; without the macro, the same stimulus -> oDone only after 32 CALC cycles.
